mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control FSM: decodes op/funct and drives the datapath strobes and the
//  3-bit alucont word consumed by the ALU (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
//  Sits beside the datapath. Sequences fetch/decode/execute/memory/writeback.
//  Stalls on a req/ready memory handshake, with a timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  wait cycles without mem_ready before abort; legal range 2..255
// PORTS
//  clk        in   1  single clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  op         in   6  instr[31:26], valid from DECODE onward
//  funct      in   6  instr[5:0]
//  zero       in   1  ALU zero flag (BEQEX)
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request
//  memwrite   out  1  write strobe (with mem_req in MEMWR)
//  irwrite    out  1  load instruction register
//  pcen       out  1  PC enable = pcwrite | (branch & zero)
//  regwrite   out  1  register file write
//  regdst     out  1  1: rd, 0: rt
//  memtoreg   out  1  1: memory data, 0: ALU out
//  iord       out  1  1: data address, 0: PC
//  alusrca    out  1  1: reg A, 0: PC
//  alusrcb    out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc      out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alucont    out  3  ALU operation, encoding as above
//  illegal_op out  1  one-cycle pulse: unsupported op/funct
//  mem_err    out  1  one-cycle pulse: memory timeout
//  state      out  4  current state code (debug)
// BEHAVIOUR
//  - Reset: state=FETCH(0), wait counter 0.
//  - While reset_n low: all strobes 0; this covers mem_req, memwrite, irwrite, pcen,
//    regwrite, illegal_op and mem_err. Mux selects 0.
//  - Reset asserted mid-access aborts that access. No write completes.
//  - Outputs are Moore decodes of state. Exceptions:
//    - irwrite and pcen in FETCH assert only in the cycle mem_ready=1.
//    - pcen in BEQEX is qualified by zero.
//  - State codes and transitions:
//    - FETCH(0): iord0 srca0 srcb01 alucont010 pcsrc00 mem_req. On ready: irwrite, pcwrite -> DECODE.
//    - DECODE(1): srca0 srcb11 alucont010. Next state by op:
//      lw/sw(100011/101011) -> MEMADR; R(000000) -> RTYPEEX; beq(000100) -> BEQEX;
//      addi(001000) -> ADDIEX; j(000010) -> JEX; other -> illegal_op pulse, FETCH.
//    - MEMADR(2): srca1 srcb10 alucont010. lw -> MEMRD, sw -> MEMWR.
//    - MEMRD(3): iord1 mem_req. On ready -> MEMWB.
//    - MEMWB(4): regdst0 memtoreg1 regwrite -> FETCH.
//    - MEMWR(5): iord1 mem_req memwrite. On ready -> FETCH.
//    - RTYPEEX(6): srca1 srcb00, alucont from funct:
//      100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
//      Any other funct: alucont=010, illegal_op pulse, next state FETCH (no writeback).
//      Legal funct -> RTYPEWB.
//    - RTYPEWB(7): regdst1 memtoreg0 regwrite -> FETCH.
//    - BEQEX(8): srca1 srcb00 alucont110 pcsrc01 branch -> FETCH.
//    - ADDIEX(9): srca1 srcb10 alucont010 -> ADDIWB.
//    - ADDIWB(10): regdst0 memtoreg0 regwrite -> FETCH.
//    - JEX(11): pcsrc10 pcwrite -> FETCH.
//    - Codes 12-15: unreachable; recover to FETCH next cycle, no strobes.
//  - Wait counter (8 bit):
//    - Increments each cycle mem_req=1 and mem_ready=0.
//    - Clears on any state change.
//    - When it reaches MEM_TIMEOUT-1 with mem_ready still 0: mem_err pulse, counter cleared,
//      next state FETCH (FETCH retries at the same PC). No irwrite, pcen or memwrite-completion.
//  - mem_ready outside request states is ignored.
//  - mem_ready in the same cycle as the timeout threshold: ready wins, no mem_err.
//  - Unlisted outputs are 0 in each state.
//  - Cycle counts with ready in the first cycle: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// TESTING
//  - Reset low 3 cycles mid-MEMWR (mem_ready=0) -> all strobes 0 during reset; state=0 after;
//    first FETCH with mem_req=1.
//  - add (op 000000, funct 100000), ready immediate -> 4 cycles: states 0,1,6,7;
//    alucont=010 in RTYPEEX; regwrite=1, regdst=1 in RTYPEWB.
//  - lw with mem_ready delayed 3 cycles in FETCH and MEMRD -> states held;
//    irwrite exactly once; total 11 cycles; regwrite=1, memtoreg=1 in MEMWB.
//  - beq: zero=1 -> pcen=1 in BEQEX; zero=0 -> pcen=0; alucont=110, pcsrc=01.
//  - MEM_TIMEOUT=16, mem_ready never asserted in MEMRD -> mem_err pulse on wait cycle 16;
//    next state FETCH; no regwrite.
//  - op=111111 -> illegal_op one pulse in DECODE, then FETCH.
//    R-type funct=000000 -> illegal_op pulse in RTYPEEX, no regwrite.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM with a timed req/ready memory handshake
module mc_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       req, pcwrite, branch, timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      cur <= nxt;
      // a timeout in FETCH keeps the state, so it must clear the count explicitly
      if (nxt != cur || timeout)
        wait_cnt <= 8'd0;
      else if (req && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    nxt        = cur;
    req        = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    timeout    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucont    = 3'b000;
    illegal_op = 1'b0;
    case (cur)
      S_FETCH: begin
        req     = 1'b1;
        alusrcb = 2'b01;
        alucont = 3'b010;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        alucont = 3'b010;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = 3'b010;
        nxt     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        req  = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        req      = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        nxt     = S_RTYPEWB;
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default: begin
            alucont    = 3'b010;
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        alucont = 3'b110;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        nxt     = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = 3'b010;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        nxt     = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    // ready on the threshold cycle still completes the access
    if (req && !mem_ready && wait_cnt == TMO_LAST) begin
      timeout = 1'b1;
      nxt     = S_FETCH;
    end

    mem_req = req;
    mem_err = timeout;
    pcen    = pcwrite | (branch & zero);

    if (!reset_n) begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucont    = 3'b000;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  localparam int TMO = 16;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, iord, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  logic       illegal_op, mem_err;
  logic [3:0] state;

  mc_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucont(alucont), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucont;
    logic       illegal_op, mem_err;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
  } stim_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cycles;
    int         regw;
    int         pcens;
    int         ills;
    bit         chk_alu;
    logic [2:0] alu;
  } vec_t;

  obs_t  obs_now;
  stim_t sq[$];
  obs_t  eq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  assign obs_now = {state, mem_req, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, iord,
                    alusrca, alusrcb, pcsrc, alucont, illegal_op, mem_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic bit op_legal(input logic [5:0] o);
    return o inside {RT, JMP, BEQ, ADDI, LW, SW};
  endfunction

  function automatic bit funct_legal(input logic [5:0] f);
    return f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Moore output table: what each state shows when no handshake or qualifier is involved
  function automatic obs_t base(input logic [3:0] s);
    obs_t o;
    o = '0;
    o.state = s;
    case (s)
      4'd0:  begin o.mem_req = 1; o.alusrcb = 2'b01; o.alucont = 3'b010; end
      4'd1:  begin o.alusrcb = 2'b11; o.alucont = 3'b010; end
      4'd2:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucont = 3'b010; end
      4'd3:  begin o.iord = 1; o.mem_req = 1; end
      4'd4:  begin o.memtoreg = 1; o.regwrite = 1; end
      4'd5:  begin o.iord = 1; o.mem_req = 1; o.memwrite = 1; end
      4'd6:  o.alusrca = 1;
      4'd7:  begin o.regdst = 1; o.regwrite = 1; end
      4'd8:  begin o.alusrca = 1; o.alucont = 3'b110; o.pcsrc = 2'b01; end
      4'd9:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucont = 3'b010; end
      4'd10: o.regwrite = 1;
      4'd11: begin o.pcsrc = 2'b10; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input obs_t e, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r);
    sq.push_back(stim_t'{o, f, z, r});
    eq.push_back(e);
  endtask

  // a request state held for d cycles: d>=TMO means abort on the TMO-th cycle
  task automatic mem_phase(input logic [3:0] s, input int d, input logic [5:0] o,
                           input logic [5:0] f, output bit done);
    obs_t e;
    if (d >= TMO) begin
      for (int i = 0; i < TMO - 1; i++) push(base(s), o, f, 1'($urandom), 1'b0);
      e = base(s);
      e.mem_err = 1;
      push(e, o, f, 1'($urandom), 1'b0);
      done = 0;
    end else begin
      for (int i = 0; i < d; i++) push(base(s), o, f, 1'($urandom), 1'b0);
      push(base(s), o, f, 1'($urandom), 1'b1);
      done = 1;
    end
  endtask

  // expected per-cycle trace of one instruction, given its fetch and data-memory delays
  task automatic add_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int df, input int dm);
    obs_t e;
    int   d;
    bit   done;
    d = df;
    while (d >= TMO) begin
      for (int i = 0; i < TMO - 1; i++) push(base(0), r6(), r6(), 1'($urandom), 1'b0);
      e = base(0);
      e.mem_err = 1;
      push(e, r6(), r6(), 1'($urandom), 1'b0);
      d -= TMO;
    end
    for (int i = 0; i < d; i++) push(base(0), r6(), r6(), 1'($urandom), 1'b0);
    e = base(0);
    e.irwrite = 1;
    e.pcen = 1;
    push(e, r6(), r6(), 1'($urandom), 1'b1);
    e = base(1);
    e.illegal_op = !op_legal(o);
    push(e, o, f, 1'($urandom), 1'($urandom));
    if (!op_legal(o)) return;
    case (o)
      LW, SW: begin
        push(base(2), o, f, 1'($urandom), 1'($urandom));
        mem_phase((o == SW) ? 4'd5 : 4'd3, dm, o, f, done);
        if (done && o == LW) push(base(4), o, f, 1'($urandom), 1'($urandom));
      end
      RT: begin
        e = base(6);
        e.alucont = ref_alu(f);
        e.illegal_op = !funct_legal(f);
        push(e, o, f, 1'($urandom), 1'($urandom));
        if (funct_legal(f)) push(base(7), o, f, 1'($urandom), 1'($urandom));
      end
      BEQ: begin
        e = base(8);
        e.pcen = z;
        push(e, o, f, z, 1'($urandom));
      end
      ADDI: begin
        push(base(9), o, f, 1'($urandom), 1'($urandom));
        push(base(10), o, f, 1'($urandom), 1'($urandom));
      end
      default: push(base(11), o, f, 1'($urandom), 1'($urandom));
    endcase
  endtask

  // entry and exit just after a falling edge
  task automatic run_sched();
    stim_t s;
    obs_t  e;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      op = s.op;
      funct = s.funct;
      zero = s.zero;
      mem_ready = s.rdy;
      #1;
      check($sformatf("sched cyc %0d st %0d", cyc, e.state), 32'(obs_now), 32'(e));
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         n, regw, pcs, ills;
    logic [2:0] alu;
    n = 0; regw = 0; pcs = 0; ills = 0; alu = 3'b000;
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c > 0 && state == 4'd0) begin
        n = c;
        break;
      end
      regw += int'(regwrite);
      pcs  += int'(pcen);
      ills += int'(illegal_op);
      if (c == 2) alu = alucont;
      @(negedge clk);
    end
    check($sformatf("vec%0d cycles", idx), 32'(n), 32'(v.cycles));
    check($sformatf("vec%0d regwrites", idx), 32'(regw), 32'(v.regw));
    check($sformatf("vec%0d pcen", idx), 32'(pcs), 32'(v.pcens));
    check($sformatf("vec%0d illegal_op", idx), 32'(ills), 32'(v.ills));
    if (v.chk_alu) check($sformatf("vec%0d alucont", idx), 32'(alu), 32'(v.alu));
  endtask

  function automatic int rand_delay();
    int p;
    p = $urandom_range(0, 19);
    if (p < 14) return $urandom_range(0, 3);
    if (p < 16) return TMO - 1;
    if (p < 18) return TMO;
    return $urandom_range(TMO + 1, 40);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t       vt[14];
    obs_t       e;
    logic [5:0] lf[5];
    logic [5:0] o, f;

    lf = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    vt[0]  = '{LW,         6'd0,      1'b0, 5, 1, 1, 0, 1'b1, 3'b010};
    vt[1]  = '{SW,         6'd0,      1'b0, 4, 0, 1, 0, 1'b1, 3'b010};
    vt[2]  = '{RT,         6'b100000, 1'b0, 4, 1, 1, 0, 1'b1, 3'b010};
    vt[3]  = '{RT,         6'b100010, 1'b0, 4, 1, 1, 0, 1'b1, 3'b110};
    vt[4]  = '{RT,         6'b100100, 1'b0, 4, 1, 1, 0, 1'b1, 3'b000};
    vt[5]  = '{RT,         6'b100101, 1'b0, 4, 1, 1, 0, 1'b1, 3'b001};
    vt[6]  = '{RT,         6'b101010, 1'b0, 4, 1, 1, 0, 1'b1, 3'b111};
    vt[7]  = '{RT,         6'b000000, 1'b0, 3, 0, 1, 1, 1'b1, 3'b010};
    vt[8]  = '{BEQ,        6'd0,      1'b1, 3, 0, 2, 0, 1'b1, 3'b110};
    vt[9]  = '{BEQ,        6'd0,      1'b0, 3, 0, 1, 0, 1'b1, 3'b110};
    vt[10] = '{ADDI,       6'd0,      1'b0, 4, 1, 1, 0, 1'b1, 3'b010};
    vt[11] = '{JMP,        6'd0,      1'b0, 3, 0, 2, 0, 1'b1, 3'b000};
    vt[12] = '{6'b111111,  6'd0,      1'b0, 2, 0, 1, 1, 1'b0, 3'b000};
    vt[13] = '{6'b000001,  6'd0,      1'b0, 2, 0, 1, 1, 1'b0, 3'b000};

    reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b1; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset outputs", 32'(obs_now), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

    add_instr(RT, 6'b100000, 1'b0, 0, 0);
    add_instr(LW, r6(), 1'b0, 3, 3);
    add_instr(BEQ, r6(), 1'b1, 0, 0);
    add_instr(BEQ, r6(), 1'b0, 0, 0);
    add_instr(LW, r6(), 1'b0, 0, TMO);
    add_instr(6'b111111, r6(), 1'b0, 0, 0);
    add_instr(RT, 6'b000000, 1'b0, 0, 0);
    add_instr(SW, r6(), 1'b0, 1, TMO - 1);
    add_instr(SW, r6(), 1'b0, 0, TMO);
    add_instr(ADDI, r6(), 1'b0, 40, 0);
    add_instr(JMP, r6(), 1'b0, TMO - 1, 0);
    run_sched();

    // abort a store mid-handshake with an asynchronous reset
    f = r6();
    e = base(0);
    e.irwrite = 1;
    e.pcen = 1;
    push(e, SW, f, 1'b0, 1'b1);
    push(base(1), SW, f, 1'b0, 1'b1);
    push(base(2), SW, f, 1'b0, 1'b1);
    push(base(5), SW, f, 1'b0, 1'b0);
    push(base(5), SW, f, 1'b0, 1'b0);
    run_sched();
    reset_n = 1'b0;
    mem_ready = 1'b0;
    repeat (3) begin
      #1;
      check("reset mid-memwr outputs", 32'(obs_now), 32'd0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    add_instr(SW, r6(), 1'b0, TMO - 1, 0);
    run_sched();

    repeat (60) begin
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2, 3: o = RT;
        4: o = BEQ;
        5: o = ADDI;
        6: o = JMP;
        default: begin
          o = r6();
          while (op_legal(o)) o = r6();
        end
      endcase
      f = ($urandom_range(0, 3) == 0) ? r6() : lf[$urandom_range(0, 4)];
      add_instr(o, f, 1'($urandom), rand_delay(), rand_delay());
    end
    run_sched();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
